// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MEM_READ   = 2'd1,
        WRITE_LINE = 2'd2
    } state_t;

    localparam int LINE_W       = 128;
    localparam int BLOCK_ADDR_W = 28;
    localparam int WORD_SEL_W   = 2;

    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                              input logic [WORD_SEL_W-1:0] sel);
        return line[32*sel +: 32];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: one write port, one
// combinational read port with tag compare and word select.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    input  logic [WORD_SEL_W-1:0] rd_word_sel,
    output logic                  rd_hit,
    output logic [31:0]           rd_word,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic                  wr_valid,
    input  logic                  inval_all
);

    logic [NUM_SETS-1:0] valid_reg;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [LINE_W-1:0]   data_mem [NUM_SETS];

    // Tag and data are never reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
            logic valid_bit_reg;

            // A bulk invalidate wins over a same-edge install.
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    valid_bit_reg <= 1'b0;
                else if (inval_all)
                    valid_bit_reg <= 1'b0;
                else if (wr_en && (wr_index == INDEX_W'(gi)))
                    valid_bit_reg <= wr_valid;
            end

            assign valid_reg[gi] = valid_bit_reg;
        end
    endgenerate

    assign rd_hit  = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_word = line_word(data_mem[rd_index], rd_word_sel);

endmodule

// File: rtl/icache_dm_controller.sv
// Direct-mapped instruction cache controller: zero-wait hits, 16-byte block
// refill from byte-serial memory, flush support and saturating hit/miss counters.
module icache_dm_controller
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3,
    parameter int TAG_W    = 28 - INDEX_W,
    parameter int CNT_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_read,
    input  logic [31:0]             cpu_address,
    input  logic                    flush,
    output logic [31:0]             cpu_instruction,
    output logic                    cpu_busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]       mem_readdata,
    input  logic                    mem_busywait,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state_reg, state_next;
    logic [BLOCK_ADDR_W-1:0] miss_addr_reg, miss_addr_next;
    logic                    flush_pending_reg, flush_pending_next;
    logic [CNT_W-1:0]        hit_count_reg, hit_count_next;
    logic [CNT_W-1:0]        miss_count_reg, miss_count_next;

    logic                    hit;
    logic [31:0]             hit_word;
    logic                    wr_en;
    logic                    wr_valid;
    logic                    inval_all;
    logic                    addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_address[1:0];

    icache_line_store #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W)
    ) u_line_store (
        .clock       (clock),
        .reset       (reset),
        .rd_index    (cpu_address[3+INDEX_W:4]),
        .rd_tag      (cpu_address[31:4+INDEX_W]),
        .rd_word_sel (cpu_address[3:2]),
        .rd_hit      (hit),
        .rd_word     (hit_word),
        .wr_en       (wr_en),
        .wr_index    (miss_addr_reg[INDEX_W-1:0]),
        .wr_tag      (miss_addr_reg[BLOCK_ADDR_W-1 -: TAG_W]),
        .wr_data     (mem_readdata),
        .wr_valid    (wr_valid),
        .inval_all   (inval_all)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            miss_addr_reg     <= '0;
            flush_pending_reg <= 1'b0;
            hit_count_reg     <= '0;
            miss_count_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            miss_addr_reg     <= miss_addr_next;
            flush_pending_reg <= flush_pending_next;
            hit_count_reg     <= hit_count_next;
            miss_count_reg    <= miss_count_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        miss_addr_next     = miss_addr_reg;
        flush_pending_next = flush_pending_reg;
        hit_count_next     = hit_count_reg;
        miss_count_next    = miss_count_reg;
        cpu_busywait       = 1'b0;
        mem_read           = 1'b0;
        wr_en              = 1'b0;
        wr_valid           = 1'b0;
        inval_all          = 1'b0;

        case (state_reg)
            IDLE: begin
                // A flush stalls the fetch for this cycle; the retry then misses.
                cpu_busywait = cpu_read && (!hit || flush);
                if (flush) begin
                    inval_all = 1'b1;
                end else if (cpu_read && hit) begin
                    if (hit_count_reg != CNT_MAX)
                        hit_count_next = hit_count_reg + 1'b1;
                end else if (cpu_read) begin
                    miss_addr_next = cpu_address[31:4];
                    if (miss_count_reg != CNT_MAX)
                        miss_count_next = miss_count_reg + 1'b1;
                    state_next = MEM_READ;
                end
            end

            MEM_READ: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
                if (flush)
                    flush_pending_next = 1'b1;
                if (!mem_busywait)
                    state_next = WRITE_LINE;
            end

            WRITE_LINE: begin
                // Last byte lands one edge after busywait drops, so install here.
                cpu_busywait       = 1'b1;
                wr_en              = 1'b1;
                inval_all          = flush_pending_reg || flush;
                wr_valid           = !(flush_pending_reg || flush);
                flush_pending_next = 1'b0;
                state_next         = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign cpu_instruction = hit ? hit_word : 32'h0;
    assign mem_address     = miss_addr_reg;
    assign hit_count       = hit_count_reg;
    assign miss_count      = miss_count_reg;

endmodule
